// File: rtl/pid_sched_engine.sv
// Shared-multiplier PID engine time-multiplexed across NCH control loops.
// Each channel runs CAPT/MULP/MULI/MULD/UPD once per sample tick.
module pid_sched_engine #(
  parameter int NCH   = 4,
  parameter int DIV   = 256,
  parameter int SHIFT = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [8*NCH-1:0] setpoint_flat,
  input  logic [8*NCH-1:0] feedback_flat,
  input  logic             cfg_we,
  input  logic [1:0]       cfg_addr,
  input  logic [7:0]       cfg_data,
  output logic [8*NCH-1:0] ctrl_flat,
  output logic             out_valid,
  output logic [2:0]       out_ch,
  output logic             busy,
  output logic             overrun
);

  localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int CHW = (NCH > 1) ? $clog2(NCH) : 1;
  localparam logic signed [18:0] IMAX = 19'sd32767;
  localparam logic signed [18:0] IMIN = -19'sd32768;

  typedef enum logic [2:0] {
    IDLE, CAPT, MULP, MULI, MULD, UPD
  } state_e;

  state_e         state_q, state_d;
  logic [CHW-1:0] ch_q, ch_d;
  logic [CW-1:0]  cnt_q;
  logic           tick, last;

  logic [7:0] kp_q, ki_q, kd_q;
  logic [7:0] kp_d, ki_d, kd_d;
  logic [7:0] skp_q, ski_q, skd_q;
  logic [7:0] skp_d, ski_d, skd_d;

  logic signed [8:0]  e_q;
  logic signed [16:0] p_q;
  logic signed [15:0] inew_q;
  logic signed [18:0] d_q;
  logic signed [15:0] integ_q [NCH];
  logic signed [8:0]  prev_q  [NCH];
  logic [NCH-1:0]     sat_hi_q, sat_lo_q;
  logic [7:0]         ctrl_q  [NCH];
  logic               ov_q, out_valid_q;
  logic [2:0]         out_ch_q;

  logic [7:0]         sp, fb;
  logic signed [8:0]  e_cap;
  logic signed [9:0]  diff;
  logic signed [18:0] ma, mb, prod;
  logic signed [18:0] acc;
  logic signed [15:0] icand;
  logic               hold;
  logic signed [19:0] sum, y;
  logic               y_neg, y_big;

  assign tick = (cnt_q == CW'(DIV - 1));
  assign last = (ch_q == CHW'(NCH - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      ch_q    <= '0;
    end else begin
      state_q <= state_d;
      ch_q    <= ch_d;
    end
  end

  always_comb begin
    state_d = state_q;
    ch_d    = ch_q;
    unique case (state_q)
      IDLE: if (tick) begin
        state_d = CAPT;
        ch_d    = '0;
      end
      CAPT: state_d = MULP;
      MULP: state_d = MULI;
      MULI: state_d = MULD;
      MULD: state_d = UPD;
      UPD: begin
        state_d = last ? IDLE : CAPT;
        ch_d    = last ? ch_q : ch_q + CHW'(1);
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy      = (state_q != IDLE);
    overrun   = ov_q;
    out_valid = out_valid_q;
    out_ch    = out_ch_q;
  end

  // Shadow always takes writes; live follows it only outside a round.
  always_comb begin
    skp_d = skp_q;
    ski_d = ski_q;
    skd_d = skd_q;
    if (cfg_we) begin
      case (cfg_addr)
        2'd0:    skp_d = cfg_data;
        2'd1:    ski_d = cfg_data;
        2'd2:    skd_d = cfg_data;
        default: ;
      endcase
    end
    kp_d = kp_q;
    ki_d = ki_q;
    kd_d = kd_q;
    if ((state_q == IDLE && !tick) || (state_q == UPD && last)) begin
      kp_d = skp_d;
      ki_d = ski_d;
      kd_d = skd_d;
    end
  end

  always_comb begin
    sp    = setpoint_flat[8*ch_q +: 8];
    fb    = feedback_flat[8*ch_q +: 8];
    e_cap = $signed({1'b0, sp}) - $signed({1'b0, fb});
    diff  = {e_q[8], e_q} - {prev_q[ch_q][8], prev_q[ch_q]};
    ma    = '0;
    mb    = {{10{e_q[8]}}, e_q};
    unique case (1'b1)
      state_q == MULP: ma = {11'd0, kp_q};
      state_q == MULI: ma = {11'd0, ki_q};
      state_q == MULD: begin
        ma = {11'd0, kd_q};
        mb = {{9{diff[9]}}, diff};
      end
      default: ;
    endcase
    prod  = ma * mb;
    acc   = {{3{integ_q[ch_q][15]}}, integ_q[ch_q]} + prod;
    icand = (acc > IMAX) ? IMAX[15:0] :
            (acc < IMIN) ? IMIN[15:0] : acc[15:0];
    hold  = (sat_hi_q[ch_q] && !e_q[8] && (e_q != '0)) ||
            (sat_lo_q[ch_q] && e_q[8]);
    sum   = {{3{p_q[16]}}, p_q} + {{4{inew_q[15]}}, inew_q} +
            {d_q[18], d_q};
    y     = sum >>> SHIFT;
    y_neg = y[19];
    y_big = !y[19] && (|y[18:8]);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q       <= '0;
      ov_q        <= 1'b0;
      out_valid_q <= 1'b0;
      out_ch_q    <= '0;
      kp_q        <= 8'h10;
      ki_q        <= 8'h02;
      kd_q        <= 8'h01;
      skp_q       <= 8'h10;
      ski_q       <= 8'h02;
      skd_q       <= 8'h01;
      e_q         <= '0;
      p_q         <= '0;
      inew_q      <= '0;
      d_q         <= '0;
      sat_hi_q    <= '0;
      sat_lo_q    <= '0;
      for (int c = 0; c < NCH; c++) begin
        integ_q[c] <= '0;
        prev_q[c]  <= '0;
        ctrl_q[c]  <= '0;
      end
    end else begin
      cnt_q       <= tick ? '0 : cnt_q + CW'(1);
      ov_q        <= ov_q | (tick && state_q != IDLE);
      out_valid_q <= 1'b0;
      kp_q        <= kp_d;
      ki_q        <= ki_d;
      kd_q        <= kd_d;
      skp_q       <= skp_d;
      ski_q       <= ski_d;
      skd_q       <= skd_d;
      if (state_q == CAPT) e_q <= e_cap;
      if (state_q == MULP) p_q <= prod[16:0];
      if (state_q == MULI) inew_q <= hold ? integ_q[ch_q] : icand;
      if (state_q == MULD) d_q <= prod;
      if (state_q == UPD) begin
        integ_q[ch_q]  <= inew_q;
        prev_q[ch_q]   <= e_q;
        sat_hi_q[ch_q] <= y_big;
        sat_lo_q[ch_q] <= y_neg;
        ctrl_q[ch_q]   <= y_neg ? 8'd0 : y_big ? 8'd255 : y[7:0];
        out_valid_q    <= 1'b1;
        out_ch_q       <= 3'(ch_q);
      end
    end
  end

  always_comb begin
    ctrl_flat = '0;
    for (int c = 0; c < NCH; c++) ctrl_flat[8*c +: 8] = ctrl_q[c];
  end

endmodule

// File: tb/tb_pid_sched_engine.sv
// Directed bench for pid_sched_engine: settle, clamp, anti-windup,
// gain writes, mid-round reset and overrun on a short-period instance.
module tb_pid_sched_engine;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, rst_b;
  logic [31:0] sp, fb;
  logic        cfg_we;
  logic [1:0]  cfg_addr;
  logic [7:0]  cfg_data;
  logic        cfg_we_b = 1'b0;
  logic [1:0]  cfg_addr_b = 2'd0;
  logic [7:0]  cfg_data_b = 8'd0;

  logic [31:0] ctrl_flat, ctrl_flat_b;
  logic        out_valid, busy, overrun;
  logic        out_valid_b, busy_b, overrun_b;
  logic [2:0]  out_ch, out_ch_b;

  int checks = 0;
  int failures = 0;

  pid_sched_engine #(.NCH(4), .DIV(64), .SHIFT(4)) dut (
    .clk(clk), .rst(rst),
    .setpoint_flat(sp), .feedback_flat(fb),
    .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
    .ctrl_flat(ctrl_flat), .out_valid(out_valid), .out_ch(out_ch),
    .busy(busy), .overrun(overrun)
  );

  pid_sched_engine #(.NCH(4), .DIV(20), .SHIFT(4)) dut_ov (
    .clk(clk), .rst(rst_b),
    .setpoint_flat(sp), .feedback_flat(fb),
    .cfg_we(cfg_we_b), .cfg_addr(cfg_addr_b), .cfg_data(cfg_data_b),
    .ctrl_flat(ctrl_flat_b), .out_valid(out_valid_b), .out_ch(out_ch_b),
    .busy(busy_b), .overrun(overrun_b)
  );

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic wait_busy(input logic lvl, input string tag);
    int n = 0;
    while (busy !== lvl && n < 200) begin
      @(negedge clk);
      n++;
    end
    check(tag, {31'd0, busy}, {31'd0, lvl});
  endtask

  task automatic gain_write(input logic [1:0] a, input logic [7:0] d);
    cfg_we   = 1'b1;
    cfg_addr = a;
    cfg_data = d;
    @(negedge clk);
    cfg_we   = 1'b0;
  endtask

  initial begin
    int n;
    int idx;
    rst      = 1'b1;
    rst_b    = 1'b1;
    cfg_we   = 1'b0;
    cfg_addr = 2'd0;
    cfg_data = 8'd0;
    sp = {8'd100, 8'd0,   8'd255, 8'd100};
    fb = {8'd60,  8'd200, 8'd0,   8'd60};
    repeat (3) @(negedge clk);
    check("rst_ctrl", ctrl_flat, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_ovr", {31'd0, overrun}, 32'd0);
    check("rst_vld", {31'd0, out_valid}, 32'd0);
    rst = 1'b0;

    wait_busy(1'b1, "r1_start");
    repeat (5) @(negedge clk);
    check("r1_vld", {31'd0, out_valid}, 32'd1);
    check("r1_ch", {29'd0, out_ch}, 32'd0);
    check("r1_ctrl0", {24'd0, ctrl_flat[7:0]}, 32'd47);
    wait_busy(1'b0, "r1_end");
    check("r1_ctrl1", {24'd0, ctrl_flat[15:8]}, 32'd255);
    check("r1_ctrl2", {24'd0, ctrl_flat[23:16]}, 32'd0);
    check("r1_ctrl3", {24'd0, ctrl_flat[31:24]}, 32'd47);

    wait_busy(1'b1, "r2_start");
    wait_busy(1'b0, "r2_end");
    check("r2_ctrl0", {24'd0, ctrl_flat[7:0]}, 32'd50);
    check("r2_ctrl1", {24'd0, ctrl_flat[15:8]}, 32'd255);
    check("r2_ctrl2", {24'd0, ctrl_flat[23:16]}, 32'd0);
    check("r2_ctrl3", {24'd0, ctrl_flat[31:24]}, 32'd50);

    fb = {8'd60, 8'd200, 8'd255, 8'd60};
    wait_busy(1'b1, "r3_start");
    wait_busy(1'b0, "r3_end");
    check("r3_ctrl0", {24'd0, ctrl_flat[7:0]}, 32'd55);
    check("r3_ctrl1", {24'd0, ctrl_flat[15:8]}, 32'd15);
    check("r3_ctrl2", {24'd0, ctrl_flat[23:16]}, 32'd0);
    check("r3_ovr", {31'd0, overrun}, 32'd0);

    gain_write(2'd0, 8'h40);
    wait_busy(1'b1, "r4_start");
    repeat (5) @(negedge clk);
    check("r4_vld", {31'd0, out_valid}, 32'd1);
    check("r4_ctrl0", {24'd0, ctrl_flat[7:0]}, 32'd180);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("mrst_ctrl", ctrl_flat, 32'd0);
    check("mrst_busy", {31'd0, busy}, 32'd0);
    check("mrst_vld", {31'd0, out_valid}, 32'd0);
    check("mrst_ovr", {31'd0, overrun}, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check("mrst_vld2", {31'd0, out_valid}, 32'd0);

    wait_busy(1'b1, "r5_start");
    repeat (2) @(negedge clk);
    gain_write(2'd0, 8'h20);
    wait_busy(1'b0, "r5_end");
    check("r5_ctrl0", {24'd0, ctrl_flat[7:0]}, 32'd47);
    check("r5_ctrl1", {24'd0, ctrl_flat[15:8]}, 32'd0);
    check("r5_ctrl3", {24'd0, ctrl_flat[31:24]}, 32'd47);

    gain_write(2'd3, 8'h00);
    wait_busy(1'b1, "r6_start");
    wait_busy(1'b0, "r6_end");
    check("r6_ctrl0", {24'd0, ctrl_flat[7:0]}, 32'd90);
    check("r6_ctrl1", {24'd0, ctrl_flat[15:8]}, 32'd0);
    check("r6_ctrl3", {24'd0, ctrl_flat[31:24]}, 32'd90);
    check("r6_ovr", {31'd0, overrun}, 32'd0);

    rst_b = 1'b0;
    n = 0;
    while (busy_b !== 1'b1 && n < 60) begin
      @(negedge clk);
      n++;
    end
    check("ov_start", {31'd0, busy_b}, 32'd1);
    check("ov_pre", {31'd0, overrun_b}, 32'd0);
    idx = 0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
      if (out_valid_b) begin
        check("ov_order", {29'd0, out_ch_b}, idx);
        idx++;
      end
    end while (busy_b && n < 40);
    check("ov_pulses", idx, 32'd4);
    check("ov_flag", {31'd0, overrun_b}, 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
